// File: rtl/gate_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_sweep_pkg
// Purpose  : Shared definitions for the gate sweep sequencer: FSM state
//            encoding, standard 2-input truth tables and settle-timer width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gate_sweep_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_SETTLE = S_SETTLE,
    ST_CHECK  = S_CHECK,
    ST_DONE   = S_DONE
  } state_e;

  // Bit k is the gate output expected for input vector k.
  localparam logic [3:0] TT_OR2  = 4'b1110;
  localparam logic [3:0] TT_AND2 = 4'b1000;
  localparam logic [3:0] TT_XOR2 = 4'b0110;

  // Wide enough for the largest settle time (15).
  localparam int TMR_W = 4;

endpackage
`default_nettype wire

// File: rtl/gate_sweep_timer.sv
`default_nettype none
// ============================================================================
// Module   : gate_sweep_timer
// Purpose  : Loadable down-counter with a zero flag, used to time the settle
//            interval between driving a vector and sampling the gate.
// Ports    : clk, rst_n   - clock, asynchronous active-low reset
//            load_i/val_i - load val_i into the counter (has priority)
//            dec_i        - decrement by one, saturating at zero
//            zero_o       - counter currently reads zero
// Revision : 1.0 - initial release
// ============================================================================
module gate_sweep_timer
  import gate_sweep_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gate_sweep_ctrl
// Purpose  : Drives every input vector of a small combinational gate in
//            ascending order, waits SETTLE cycles, samples gate_y against
//            EXP_TT and reports pass / mismatch count / first failing vector.
// Ports    : clk, rst_n  - clock, asynchronous active-low reset
//            start       - sweep request (sampled only when idle)
//            gate_y      - output of the gate under test
//            gate_in     - registered vector driven to the gate
//            busy, done  - sweep in progress / one-cycle end pulse
//            pass        - last sweep had zero mismatches
//            err_cnt     - mismatch count of the current/last sweep
//            fail_vec    - first mismatching vector (valid when err_cnt != 0)
// Config   : GATE_SWEEP_STOP_ON_FAIL_EN - end the sweep on the first mismatch
// Revision : 1.0 - initial release
// ============================================================================
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int                  N_IN   = 2,
  parameter int                  SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0] EXP_TT = TT_OR2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            gate_y,
  output logic [N_IN-1:0] gate_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] fail_vec
);

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] fail_q, fail_d;
  logic            pass_q, pass_d;

  logic            tmr_load, tmr_dec, tmr_zero;
  logic            mismatch, last_vec;

  // The state is left on the edge where the counter is seen at zero, so
  // loading SETTLE-1 yields exactly SETTLE cycles spent in SETTLE.
  gate_sweep_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tmr_load),
    .val_i  (TMR_W'(SETTLE - 1)),
    .dec_i  (tmr_dec),
    .zero_o (tmr_zero)
  );

  assign mismatch = (gate_y != EXP_TT[vec_q]);
  assign last_vec = (vec_q == {N_IN{1'b1}});

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    err_d    = err_q;
    fail_d   = fail_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d    = '0;
          fail_d   = '0;
          pass_d   = 1'b0;
          vec_d    = '0;
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (tmr_zero) begin
          state_d = ST_CHECK;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_CHECK: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (err_q == '0) begin
            fail_d = vec_q;
          end
        end
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        if (mismatch || last_vec) begin
`else
        if (last_vec) begin
`endif
          // Pass is resolved here so it is already valid while done is high.
          state_d = ST_DONE;
          pass_d  = (err_d == '0);
        end else begin
          vec_d    = vec_q + 1'b1;
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  // All outputs come straight from registers.
  assign gate_in  = vec_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vec = fail_q;

endmodule
`default_nettype wire
